// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing defaults, count types and window helper
package vga_timing_pkg;

    localparam int COUNT_W = 10;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int CLK_DIV_DEF   = 2;

    typedef logic [COUNT_W-1:0] count_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_t;

    // Both syncs are active-low, so the idle/blanked state is high syncs, video off
    localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

    function automatic int span_total(input int disp, input int front, input int sync, input int back);
        return disp + front + sync + back;
    endfunction

    localparam int H_TOTAL_DEF = span_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int V_TOTAL_DEF = span_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

    function automatic logic in_window(input count_t val, input count_t first, input count_t last);
        return (val >= first) && (val <= last);
    endfunction

endpackage

// File: rtl/vga_tick_div.sv
// rtl/vga_tick_div.sv - pixel-tick divider, one registered p_tick every CLK_DIV clocks
module vga_tick_div
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic p_tick
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] r_div;
    logic       r_p_tick;
    logic       w_div_last;

    // With CLK_DIV=1 the counter sits at 0 and the tick stays high after reset
    assign w_div_last = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div    <= 4'd0;
            r_p_tick <= 1'b0;
        end else begin
            r_div    <= w_div_last ? 4'd0 : r_div + 4'd1;
            r_p_tick <= w_div_last;
        end
    end

    assign p_tick = r_p_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA counters and registered syncs; frame_cnt output with VGA_FRAME_CNT_EN
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int CLK_DIV   = CLK_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] HCount,
    output logic [9:0] VCount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam count_t H_LAST   = count_t'(H_TOTAL - 1);
    localparam count_t V_LAST   = count_t'(V_TOTAL - 1);
    localparam count_t H_VIS    = count_t'(H_DISPLAY);
    localparam count_t V_VIS    = count_t'(V_DISPLAY);
    localparam count_t HS_FIRST = count_t'(H_DISPLAY + H_FRONT);
    localparam count_t HS_LAST  = count_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam count_t VS_FIRST = count_t'(V_DISPLAY + V_FRONT);
    localparam count_t VS_LAST  = count_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    count_t r_hcount;
    count_t r_vcount;
    sync_t  r_sync;
    logic   r_frame_start;

    count_t w_h_next;
    count_t w_v_next;
    sync_t  w_sync_next;
    logic   w_tick;
    logic   w_h_wrap;
    logic   w_frame_wrap;

    vga_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .p_tick (w_tick)
    );

    // Syncs are decoded from the next counts so they land on the same edge as the counts
    always_comb begin
        w_h_wrap = (r_hcount == H_LAST);
        w_h_next = w_h_wrap ? '0 : r_hcount + 10'd1;
        w_v_next = r_vcount;
        if (w_h_wrap) begin
            w_v_next = (r_vcount == V_LAST) ? '0 : r_vcount + 10'd1;
        end
        w_frame_wrap         = w_tick && (w_h_next == '0) && (w_v_next == '0);
        w_sync_next.hsync    = !in_window(w_h_next, HS_FIRST, HS_LAST);
        w_sync_next.vsync    = !in_window(w_v_next, VS_FIRST, VS_LAST);
        w_sync_next.video_on = (w_h_next < H_VIS) && (w_v_next < V_VIS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_sync        <= SYNC_IDLE;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_wrap;
            if (w_tick) begin
                r_hcount <= w_h_next;
                r_vcount <= w_v_next;
                r_sync   <= w_sync_next;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 8'd0;
        end else if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign HCount      = r_hcount;
    assign VCount      = r_vcount;
    assign hsync       = r_sync.hsync;
    assign vsync       = r_sync.vsync;
    assign video_on    = r_sync.video_on;
    assign p_tick      = w_tick;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen on a shrunken timing (CLK_DIV 2 and 1)
module tb_vga_sync_gen;

    localparam int HD = 16, HF = 2, HS = 3, HB = 3, HT = HD + HF + HS + HB;
    localparam int VD = 8,  VF = 1, VS = 2, VB = 2, VT = VD + VF + VS + VB;
    localparam int D  = 2;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       von;
        logic       tick;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] a_h, a_v, b_h, b_v;
    logic       a_hs, a_vs, a_von, a_tick, a_fs;
    logic       b_hs, b_vs, b_von, b_tick, b_fs;
    logic [7:0] a_fc, b_fc;
    obs_t       act_a, act_b;

    obs_t q_a[$];
    obs_t q_b[$];
    int   k_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    localparam obs_t RESET_OBS = '{h: 10'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b0,
                                   tick: 1'b0, fs: 1'b0, fc: 8'd0};

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_DIV(D)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .HCount(a_h), .VCount(a_v), .hsync(a_hs), .vsync(a_vs),
        .video_on(a_von), .p_tick(a_tick), .frame_start(a_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(a_fc)
`endif
    );

    vga_sync_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_DIV(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .HCount(b_h), .VCount(b_v), .hsync(b_hs), .vsync(b_vs),
        .video_on(b_von), .p_tick(b_tick), .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(b_fc)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign a_fc = 8'd0;
    assign b_fc = 8'd0;
`endif

    assign act_a = {a_h, a_v, a_hs, a_vs, a_von, a_tick, a_fs, a_fc};
    assign act_b = {b_h, b_v, b_hs, b_vs, b_von, b_tick, b_fs, b_fc};

    // Closed-form reference: k = rising edges since reset release
    function automatic obs_t exp_at(input int k, input int d);
        obs_t e;
        int   adv, p, h, v;
        adv    = (k <= 0) ? 0 : (k - 1) / d;
        p      = adv % (HT * VT);
        h      = p % HT;
        v      = p / HT;
        e.h    = 10'(h);
        e.v    = 10'(v);
        e.hs   = !(h >= HD + HF && h <= HD + HF + HS - 1);
        e.vs   = !(v >= VD + VF && v <= VD + VF + VS - 1);
        e.von  = (adv > 0) && (h < HD) && (v < VD);
        e.tick = (k >= 1) && (k % d == 0);
        e.fs   = (k >= 2) && ((k - 1) % d == 0) && (p == 0);
`ifdef VGA_FRAME_CNT_EN
        e.fc   = 8'((adv / (HT * VT)) % 256);
`else
        e.fc   = 8'd0;
`endif
        return e;
    endfunction

    task automatic step();
        obs_t ea, eb;
        @(posedge clk);
        if (rst_n) k_cnt++;
        q_a.push_back(exp_at(k_cnt, D));
        q_b.push_back(exp_at(k_cnt, 1));
        @(negedge clk);
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        vectors++;
        if (act_a !== ea) begin
            miscompares++;
            $display("FAIL sb_div2 k=%0d: got h=%0d v=%0d hs=%b vs=%b von=%b tick=%b fs=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b von=%b tick=%b fs=%b fc=%0d",
                     k_cnt, act_a.h, act_a.v, act_a.hs, act_a.vs, act_a.von, act_a.tick, act_a.fs, act_a.fc,
                     ea.h, ea.v, ea.hs, ea.vs, ea.von, ea.tick, ea.fs, ea.fc);
        end
        vectors++;
        if (act_b !== eb) begin
            miscompares++;
            $display("FAIL sb_div1 k=%0d: got h=%0d v=%0d hs=%b vs=%b von=%b tick=%b fs=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b von=%b tick=%b fs=%b fc=%0d",
                     k_cnt, act_b.h, act_b.v, act_b.hs, act_b.vs, act_b.von, act_b.tick, act_b.fs, act_b.fc,
                     eb.h, eb.v, eb.hs, eb.vs, eb.von, eb.tick, eb.fs, eb.fc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        k_cnt = 0;
        repeat (3) step();
        vectors++;
        if (act_a !== RESET_OBS) begin
            miscompares++;
            $display("FAIL reset_state: got %h, expected %h", act_a, RESET_OBS);
        end
    endtask

    task automatic test_first_tick();
        rst_n = 1'b1;
        step();
        vectors++;
        if (a_tick !== 1'b0 || b_tick !== 1'b1) begin
            miscompares++;
            $display("FAIL first_edge_tick: got div2=%b div1=%b, expected div2=0 div1=1", a_tick, b_tick);
        end
        step();
        vectors++;
        if (a_tick !== 1'b1 || a_h !== 10'd0) begin
            miscompares++;
            $display("FAIL first_tick_at_clk2: got tick=%b h=%0d, expected tick=1 h=0", a_tick, a_h);
        end
        step();
        vectors++;
        if (a_h !== 10'd1 || a_von !== 1'b1 || a_hs !== 1'b1 || a_vs !== 1'b1 || a_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL after_first_tick: got h=%0d von=%b hs=%b vs=%b tick=%b, expected h=1 von=1 hs=1 vs=1 tick=0",
                     a_h, a_von, a_hs, a_vs, a_tick);
        end
    endtask

    task automatic test_line();
        int         hs_start = -1;
        int         hs_low = 0;
        bit         hs_done = 0;
        int         wv_before = -1;
        int         wv_after = -1;
        logic [9:0] ph, pv;
        for (int i = 0; i < 3 * HT * D; i++) begin
            ph = a_h;
            pv = a_v;
            step();
            if (!hs_done) begin
                if (a_hs === 1'b0) begin
                    if (hs_start < 0) hs_start = int'(a_h);
                    hs_low++;
                end else if (hs_start >= 0) begin
                    hs_done = 1;
                end
            end
            if (wv_after < 0 && ph == 10'(HT - 1) && a_h == 10'd0) begin
                wv_before = int'(pv);
                wv_after  = int'(a_v);
            end
        end
        vectors++;
        if (hs_start !== HD + HF) begin
            miscompares++;
            $display("FAIL hsync_start: got h=%0d, expected %0d", hs_start, HD + HF);
        end
        vectors++;
        if (hs_low !== HS * D) begin
            miscompares++;
            $display("FAIL hsync_width: got %0d clks, expected %0d", hs_low, HS * D);
        end
        vectors++;
        if (wv_before !== 0 || wv_after !== 1) begin
            miscompares++;
            $display("FAIL line_wrap: got v %0d->%0d, expected 0->1", wv_before, wv_after);
        end
    endtask

    task automatic test_frame();
        int a_first = -1, a_second = -1, b_first = -1, b_second = -1;
        int vs_low = 0, von_clks = 0, vs_start = -1, von_fall_h = -1, b_tick_low = 0;
        logic prev_von;
        for (int cyc = 0; cyc < 3 * HT * VT * D; cyc++) begin
            prev_von = a_von;
            step();
            if (a_fs === 1'b1) begin
                if (a_first < 0) a_first = cyc;
                else if (a_second < 0) a_second = cyc;
            end
            if (b_fs === 1'b1) begin
                if (b_first < 0) b_first = cyc;
                else if (b_second < 0) b_second = cyc;
            end
            if (b_tick !== 1'b1) b_tick_low++;
            if (a_first >= 0 && a_second < 0) begin
                if (a_vs === 1'b0) begin
                    if (vs_start < 0) vs_start = int'(a_v);
                    vs_low++;
                end
                if (a_von === 1'b1) von_clks++;
                if (prev_von === 1'b1 && a_von === 1'b0 && von_fall_h < 0) von_fall_h = int'(a_h);
            end
            if (a_second >= 0 && b_second >= 0) break;
        end
        vectors++;
        if (a_second < 0 || a_second - a_first !== HT * VT * D) begin
            miscompares++;
            $display("FAIL frame_period_div2: got %0d clks, expected %0d", a_second - a_first, HT * VT * D);
        end
        vectors++;
        if (b_second < 0 || b_second - b_first !== HT * VT) begin
            miscompares++;
            $display("FAIL frame_period_div1: got %0d clks, expected %0d", b_second - b_first, HT * VT);
        end
        vectors++;
        if (vs_start !== VD + VF || vs_low !== VS * HT * D) begin
            miscompares++;
            $display("FAIL vsync_window: got start=%0d low=%0d clks, expected start=%0d low=%0d",
                     vs_start, vs_low, VD + VF, VS * HT * D);
        end
        vectors++;
        if (von_clks !== HD * VD * D || von_fall_h !== HD) begin
            miscompares++;
            $display("FAIL video_on: got %0d clks fall_h=%0d, expected %0d clks fall_h=%0d",
                     von_clks, von_fall_h, HD * VD * D, HD);
        end
        vectors++;
        if (b_tick_low !== 0) begin
            miscompares++;
            $display("FAIL div1_tick_constant: got %0d low clks, expected 0", b_tick_low);
        end
    endtask

    task automatic test_mid_reset();
        bit found = 0;
        for (int i = 0; i < 2 * HT * VT * D; i++) begin
            if (a_h == 10'(HD + 4) && a_v == 10'd5) begin
                found = 1;
                break;
            end
            step();
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL mid_reset_reach: got no (%0d,5) within budget, expected to reach it", HD + 4);
        end
        #2;
        rst_n = 1'b0;
        k_cnt = 0;
        #1;
        vectors++;
        if (act_a !== RESET_OBS) begin
            miscompares++;
            $display("FAIL async_reset_div2: got %h, expected %h", act_a, RESET_OBS);
        end
        vectors++;
        if (act_b !== RESET_OBS) begin
            miscompares++;
            $display("FAIL async_reset_div1: got %h, expected %h", act_b, RESET_OBS);
        end
        repeat (4) step();
        rst_n = 1'b1;
        repeat (HT * VT * D + 2 * HT) step();
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_line();
        test_frame();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 Parameters H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_DISPLAY, default 480, visible lines per frame.
REQ-004 Parameters V_FRONT / V_SYNC / V_BACK, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter CLK_DIV, default 2, system clocks per pixel; legal range 1..16.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  system clock; all state on its rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 HCount  out  10  current pixel column; 0..H_TOTAL-1, where H_TOTAL=800 with defaults.
REQ-010 VCount  out  10  current line; 0..V_TOTAL-1, where V_TOTAL=525 with defaults.
REQ-011 hsync  out  1  horizontal sync, active-low.
REQ-012 vsync  out  1  vertical sync, active-low.
REQ-013 video_on  out  1  high when HCount<H_DISPLAY and VCount<V_DISPLAY.
REQ-014 p_tick  out  1  one-clk pulse marking each pixel advance.
REQ-015 frame_start  out  1  one-clk pulse when the counts advance to (0,0).

Function
REQ-016 The divider SHALL count 0..CLK_DIV-1 and assert p_tick for one clk when it reaches CLK_DIV-1; with CLK_DIV=1, p_tick SHALL be held high.
REQ-017 On each p_tick, HCount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and VCount SHALL increment.
REQ-018 VCount SHALL wrap from V_TOTAL-1 to 0 only on a p_tick at which HCount also wraps.
REQ-019 hsync, vsync, video_on, and frame_start SHALL be registered and updated on the same edge as the counts, so they always correspond to the HCount/VCount presented (zero relative latency).
REQ-020 hsync SHALL be low iff H_DISPLAY+H_FRONT <= HCount <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751 with defaults).
REQ-021 vsync SHALL be low iff V_DISPLAY+V_FRONT <= VCount <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491 with defaults).
REQ-022 frame_start SHALL be high for exactly one clk: the edge on which the counts become (0,0).
REQ-023 Between p_ticks, all outputs except p_tick SHALL hold their values.
REQ-024 All count arithmetic SHALL be 10-bit unsigned, and H_TOTAL and V_TOTAL SHALL not exceed 1024.

Reset
REQ-025 While rst_n is low, the block SHALL force HCount=0, VCount=0, divider=0, hsync=1, vsync=1, video_on=0, p_tick=0, and frame_start=0.
REQ-026 After rst_n rises, the first p_tick SHALL occur CLK_DIV clks later and SHALL advance HCount to 1.
REQ-027 Pixel (0,0) of the first frame after reset is blanked; no frame_start is issued until the first wrap.
REQ-028 Reset asserted mid-frame SHALL take effect immediately and asynchronously, with no glitch-free requirement on the sync lines.

Configuration
REQ-029 With macro VGA_FRAME_CNT_EN defined, the block SHALL add output frame_cnt [7:0]: reset 0, increments on each frame_start, wraps 255->0.
REQ-030 Without VGA_FRAME_CNT_EN, the frame_cnt port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-031 The default timing constants and the derived H_TOTAL/V_TOTAL SHALL live in shared package vga_timing_pkg, which is also used by the pixel renderers.
REQ-032 The pixel-tick divider SHALL be a sub-module vga_tick_div (ports clk, rst_n, p_tick).

Verification
REQ-033 Reset release with defaults -> first p_tick at clk 2; HCount=1 and video_on=1 after that tick; hsync=1 and vsync=1.
REQ-034 Run one line -> hsync low for exactly 96 p_ticks (192 clks), starting when HCount=656; HCount wraps 799->0 and VCount goes 0->1.
REQ-035 Run a full frame -> 840000 clks between frame_start pulses; vsync low for exactly 2 lines (1600 p_ticks), starting at VCount=490.
REQ-036 Observe video_on -> exactly 640*480=307200 asserted p_tick periods per frame; it deasserts at HCount=640 and at VCount=480.
REQ-037 Assert rst_n at HCount=700, VCount=300 -> all outputs return to their reset values within the same clk, with no tick until rst_n is released.
REQ-038 With VGA_FRAME_CNT_EN, run 257 frames -> frame_cnt sequence ...254, 255, 0, 1; CLK_DIV=1 -> p_tick constant high and frame period 420000 clks.
